prescale_clkdiv_gen: RTL and testbench
======================================

Name: prescale_clkdiv_gen

Overview:
- Parametrised prescale-driven divider for the UART RX clock domain.
- Decodes a one-hot PreScale (oversampling) setting into a division ratio, ratio = OS_MAX / PreScale.
- Runs a registered divide-by-ratio counter that produces a 1-cycle Div_Tick enable pulse and a near-50% Div_Clk level.
- Applies ratio changes only at period boundaries (glitch-free) and flags unsupported settings.

Parameters:
- PS_W, 6, width of PreScale input.
- OS_MAX, 32, largest supported prescale; maps to ratio 1.
- OS_MIN, 8, smallest supported prescale; must be a power of two and ≤ OS_MAX.
- RATIO_W, 8, width of Div_Ratio and the internal counter; must hold OS_MAX/OS_MIN.

Ports:
- CLK  in  1  reference clock; all flops rising-edge.
- RST  in  1  synchronous, active-high reset.
- Enable  in  1  divider run enable.
- PreScale  in  PS_W  requested oversampling value.
- Div_Ratio  out  RATIO_W  registered decoded ratio (shadow value).
- Div_Tick  out  1  one-CLK pulse at last cycle of each divided period.
- Div_Clk  out  1  registered divided level.
- Cfg_Err  out  1  registered flag: PreScale unsupported.

Behaviour:
- Decode (combinational), ratio = OS_MAX/PreScale:
  - Applies when PreScale is a power of two with OS_MIN ≤ PreScale ≤ OS_MAX.
  - Any other value, including 0 and multi-hot, decodes to ratio 1 with error = 1.
  - Defaults: 32→1, 16→2, 8→4; 4→1 with Cfg_Err.
- Shadow: each cycle Div_Ratio ← decoded ratio and Cfg_Err ← decode error. Latency from PreScale change to outputs is 1 cycle.
- Active ratio R (internal register) loads from Div_Ratio:
  - every cycle while Enable = 0 or the divider is not running;
  - while running, only on the cycle Div_Tick = 1 (period boundary).
  - A mid-period change never truncates or stretches the current period.
- Counter cnt in 0..R-1, running flag run. At each edge:
  - RST = 1: cnt = 0, run = 0, R = 1, Div_Ratio = 1, Cfg_Err = 0, Div_Tick = 0, Div_Clk = 0.
  - Enable = 0: cnt = 0, run = 0, Div_Tick = 0, Div_Clk = 0.
  - Enable = 1 and run = 0: run = 1, cnt = 0, Div_Clk = 1, Div_Tick = (R == 1).
  - Enable = 1 and run = 1: cnt = (cnt == R-1) ? 0 : cnt+1. Div_Clk = (cnt_next < (R+1)>>1). Div_Tick = (cnt_next == R_next-1), where R_next is the ratio valid for the period containing cnt_next.
- Resulting waveforms:
  - Div_Clk is high for ceil(R/2) cycles and low for floor(R/2).
  - Div_Tick occurs once per R cycles, coincident with cnt = R-1.
  - R = 1: Div_Clk held 1 and Div_Tick = 1 every enabled cycle.
- Enable deassert mid-period: outputs drop to 0 on the next edge. Re-enable restarts at cnt = 0, using the latest Div_Ratio.
- RST has priority over Enable. RST mid-period: next cycle all outputs are at reset values, and the divider restarts at cnt = 0 once RST is low and Enable is high.
- Cfg_Err does not stop the divider; it runs at ratio 1.
- Counter width: RATIO_W. No overflow is possible because R ≤ OS_MAX/OS_MIN.

Decomposition:
- Package clkdiv_pkg holds:
  - default constants OS_MAX_DEF = 32, OS_MIN_DEF = 8, RATIO_W_DEF = 8;
  - function is_pow2;
  - function prescale_to_ratio(prescale) returning {err, ratio}.
- Sub-module prescale_ratio_decode: combinational decode (generalised prescale mux), instantiated once, feeding the shadow register.
- The counter, boundary-load and output logic live in the top module.

Test Plan:
- Reset then Enable = 1, PreScale = 32 → Div_Ratio = 1, Cfg_Err = 0; Div_Tick = 1 and Div_Clk = 1 every cycle.
- PreScale = 8, Enable = 1 → Div_Ratio = 4. From the first enabled edge: Div_Clk 1,1,0,0 repeating; Div_Tick 0,0,0,1 repeating.
- OS_MAX = 48, OS_MIN = 16, PreScale = 16 → ratio 3. Div_Clk 1,1,0; Div_Tick on third cycle only.
- Running at ratio 4, change PreScale 8→16 at cnt = 1 → Div_Ratio = 2 one cycle later. Current period completes 4 cycles, then Div_Tick every 2 cycles.
- PreScale = 6'b011000 and PreScale = 4 → Cfg_Err = 1 and Div_Ratio = 1 after 1 cycle. Cfg_Err returns to 0 one cycle after PreScale = 16.
- Ratio 4 at cnt = 2: assert RST 1 cycle → all outputs 0 and Div_Ratio = 1 next cycle. After release, Div_Ratio returns to 4, then restart from cnt = 0. Separately, drop Enable at cnt = 2 → Div_Clk = 0 and no Div_Tick until re-enable.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and prescale-to-ratio decode helpers for the RX divider
package clkdiv_pkg;

    localparam int unsigned OS_MAX_DEF  = 32;
    localparam int unsigned OS_MIN_DEF  = 8;
    localparam int unsigned RATIO_W_DEF = 8;

    typedef struct packed {
        logic        err;
        logic [31:0] ratio;
    } ratio_dec_t;

    function automatic logic is_pow2(input logic [31:0] x);
        return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
    endfunction

    // One-hot prescale selects a shift of os_max, which equals os_max / prescale
    function automatic ratio_dec_t prescale_to_ratio(
        input logic [31:0] prescale,
        input int unsigned os_max = OS_MAX_DEF,
        input int unsigned os_min = OS_MIN_DEF
    );
        ratio_dec_t d;
        d.err   = 1'b1;
        d.ratio = 32'd1;
        if (is_pow2(prescale) && prescale >= os_min && prescale <= os_max)
            for (int k = 0; k < 32; k++)
                if (prescale[k]) begin
                    d.err   = 1'b0;
                    d.ratio = os_max >> k;
                end
        return d;
    endfunction

endpackage

// File: rtl/prescale_ratio_decode.sv
// prescale_ratio_decode: combinational prescale to division-ratio mux with error flag
module prescale_ratio_decode
    import clkdiv_pkg::*;
#(
    parameter int unsigned PS_W    = 6,
    parameter int unsigned OS_MAX  = OS_MAX_DEF,
    parameter int unsigned OS_MIN  = OS_MIN_DEF,
    parameter int unsigned RATIO_W = RATIO_W_DEF
) (
    input  logic [PS_W-1:0]    prescale,
    output logic [RATIO_W-1:0] ratio,
    output logic               err
);

    ratio_dec_t d;

    always_comb begin
        d     = prescale_to_ratio(32'(prescale), OS_MAX, OS_MIN);
        ratio = RATIO_W'(d.ratio);
        err   = d.err;
    end

endmodule

// File: rtl/prescale_clkdiv_gen.sv
// prescale_clkdiv_gen: prescale-driven divide-by-ratio tick and clock-level generator
module prescale_clkdiv_gen
    import clkdiv_pkg::*;
#(
    parameter int unsigned PS_W    = 6,
    parameter int unsigned OS_MAX  = OS_MAX_DEF,
    parameter int unsigned OS_MIN  = OS_MIN_DEF,
    parameter int unsigned RATIO_W = RATIO_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Enable,
    input  logic [PS_W-1:0]    PreScale,
    output logic [RATIO_W-1:0] Div_Ratio,
    output logic               Div_Tick,
    output logic               Div_Clk,
    output logic               Cfg_Err
);

    localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);

    logic [RATIO_W-1:0] dec_ratio, r, r_n, cnt, cnt_n;
    logic [RATIO_W:0]   half;
    logic               dec_err, run, tick_n, clk_n;

    prescale_ratio_decode #(
        .PS_W(PS_W), .OS_MAX(OS_MAX), .OS_MIN(OS_MIN), .RATIO_W(RATIO_W)
    ) u_dec (
        .prescale(PreScale),
        .ratio   (dec_ratio),
        .err     (dec_err)
    );

    // A running divider only adopts a new ratio as the current period closes
    always_comb begin
        r_n    = (!Enable || !run || Div_Tick) ? Div_Ratio : r;
        cnt_n  = (!Enable || !run || Div_Tick) ? '0 : cnt + ONE;
        half   = ({1'b0, r_n} + (RATIO_W+1)'(1)) >> 1;
        clk_n  = Enable && ({1'b0, cnt_n} < half);
        tick_n = Enable && (cnt_n == r_n - ONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            run       <= 1'b0;
            r         <= ONE;
            Div_Ratio <= ONE;
            Cfg_Err   <= 1'b0;
            Div_Tick  <= 1'b0;
            Div_Clk   <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            run       <= Enable;
            r         <= r_n;
            Div_Ratio <= dec_ratio;
            Cfg_Err   <= dec_err;
            Div_Tick  <= tick_n;
            Div_Clk   <= clk_n;
        end
    end

endmodule

// File: tb/tb_prescale_clkdiv_gen.sv
// tb_prescale_clkdiv_gen: table, directed and randomized checks against a queue-based period model
module tb_prescale_clkdiv_gen;

    logic       clk, rst, en, en2;
    logic [5:0] ps, ps2;
    logic [7:0] div_ratio, div_ratio2;
    logic       div_tick, div_clk, cfg_err, div_tick2, div_clk2, cfg_err2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] e_ratio;
    logic       e_err, e_tick, e_clk;
    bit         q_clk[$];
    bit         q_tick[$];

    typedef struct {
        logic [5:0] ps;
        logic [7:0] ratio;
        logic       err;
    } dec_vec_t;
    dec_vec_t vecs[10];

    prescale_clkdiv_gen u_dut (
        .CLK(clk), .RST(rst), .Enable(en), .PreScale(ps),
        .Div_Ratio(div_ratio), .Div_Tick(div_tick), .Div_Clk(div_clk), .Cfg_Err(cfg_err)
    );

    prescale_clkdiv_gen #(.OS_MAX(48), .OS_MIN(16)) u_dut48 (
        .CLK(clk), .RST(rst), .Enable(en2), .PreScale(ps2),
        .Div_Ratio(div_ratio2), .Div_Tick(div_tick2), .Div_Clk(div_clk2), .Cfg_Err(cfg_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ref_decode(input int p, input int omax, input int omin,
                              output logic [7:0] r, output logic e);
        r = 8'd1;
        e = 1'b1;
        for (int q = omin; q <= omax; q = q * 2)
            if (p == q) begin
                r = 8'(omax / p);
                e = 1'b0;
            end
    endtask

    // Each new period is laid out in full as a list of per-cycle outputs
    task automatic fill(input int r);
        for (int i = 0; i < r; i++) begin
            q_clk.push_back(i < (r + 1) / 2);
            q_tick.push_back(i == r - 1);
        end
    endtask

    task automatic step();
        if (rst) begin
            q_clk.delete(); q_tick.delete();
            e_clk = 0; e_tick = 0; e_ratio = 8'd1; e_err = 0;
        end else begin
            if (!en) begin
                q_clk.delete(); q_tick.delete();
                e_clk = 0; e_tick = 0;
            end else begin
                if (q_clk.size() == 0) fill(int'(e_ratio));
                e_clk  = q_clk.pop_front();
                e_tick = q_tick.pop_front();
            end
            ref_decode(int'(ps), 32, 8, e_ratio, e_err);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_check();
        check("model_ratio", 32'(div_ratio), 32'(e_ratio));
        check("model_err", 32'(cfg_err), 32'(e_err));
        check("model_tick", 32'(div_tick), 32'(e_tick));
        check("model_clk", 32'(div_clk), 32'(e_clk));
    endtask

    initial begin
        bit p4_clk[4]  = '{1, 1, 0, 0};
        bit p4_tick[4] = '{0, 0, 0, 1};
        bit chg_tick[6] = '{0, 1, 0, 1, 0, 1};
        bit p3_clk[3]  = '{1, 1, 0};
        bit p3_tick[3] = '{0, 0, 1};
        vecs[0] = '{6'd32, 8'd1, 1'b0};
        vecs[1] = '{6'd16, 8'd2, 1'b0};
        vecs[2] = '{6'd8,  8'd4, 1'b0};
        vecs[3] = '{6'd4,  8'd1, 1'b1};
        vecs[4] = '{6'd0,  8'd1, 1'b1};
        vecs[5] = '{6'b011000, 8'd1, 1'b1};
        vecs[6] = '{6'd1,  8'd1, 1'b1};
        vecs[7] = '{6'd2,  8'd1, 1'b1};
        vecs[8] = '{6'd63, 8'd1, 1'b1};
        vecs[9] = '{6'd48, 8'd1, 1'b1};
        e_ratio = 8'd1; e_err = 0; e_tick = 0; e_clk = 0;
        rst = 1; en = 0; ps = 6'd8; en2 = 0; ps2 = 6'd16;
        step(); step();
        check("rst_ratio", 32'(div_ratio), 32'd1);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_tick", 32'(div_tick), 32'd0);
        check("rst_clk", 32'(div_clk), 32'd0);
        rst = 0;

        foreach (vecs[i]) begin
            ps = vecs[i].ps;
            step();
            check("dec_ratio", 32'(div_ratio), 32'(vecs[i].ratio));
            check("dec_err", 32'(cfg_err), 32'(vecs[i].err));
            check("dec_idle_clk", 32'(div_clk), 32'd0);
        end

        ps = 6'd32; step();
        en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("r1_clk", 32'(div_clk), 32'd1);
            check("r1_tick", 32'(div_tick), 32'd1);
            model_check();
        end

        en = 0; ps = 6'd8; step();
        check("r4_ratio", 32'(div_ratio), 32'd4);
        en = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("r4_clk", 32'(div_clk), 32'(p4_clk[i % 4]));
            check("r4_tick", 32'(div_tick), 32'(p4_tick[i % 4]));
        end
        step(); step();
        ps = 6'd16;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) check("chg_ratio", 32'(div_ratio), 32'd2);
            check("chg_tick", 32'(div_tick), 32'(chg_tick[i]));
            model_check();
        end

        ps = 6'b011000; step();
        check("err_multi", 32'(cfg_err), 32'd1);
        check("err_multi_ratio", 32'(div_ratio), 32'd1);
        ps = 6'd4; step();
        check("err_low", 32'(cfg_err), 32'd1);
        ps = 6'd16; step();
        check("err_clear", 32'(cfg_err), 32'd0);
        check("err_clear_ratio", 32'(div_ratio), 32'd2);
        model_check();

        en = 0; ps = 6'd8; step();
        en = 1; step(); step(); step();
        check("pre_rst_clk", 32'(div_clk), 32'd0);
        rst = 1; step();
        check("mid_rst_ratio", 32'(div_ratio), 32'd1);
        check("mid_rst_clk", 32'(div_clk), 32'd0);
        check("mid_rst_tick", 32'(div_tick), 32'd0);
        rst = 0; en = 0; step();
        check("post_rst_ratio", 32'(div_ratio), 32'd4);
        en = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("restart_clk", 32'(div_clk), 32'(p4_clk[i]));
            check("restart_tick", 32'(div_tick), 32'(p4_tick[i]));
            model_check();
        end
        en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("dis_clk", 32'(div_clk), 32'd0);
            check("dis_tick", 32'(div_tick), 32'd0);
        end
        en = 1; step();
        check("reen_clk", 32'(div_clk), 32'd1);
        check("reen_tick", 32'(div_tick), 32'd0);
        model_check();

        check("os48_ratio", 32'(div_ratio2), 32'd3);
        check("os48_err", 32'(cfg_err2), 32'd0);
        en2 = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("os48_clk", 32'(div_clk2), 32'(p3_clk[i % 3]));
            check("os48_tick", 32'(div_tick2), 32'(p3_tick[i % 3]));
        end

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0)
                case ($urandom_range(0, 4))
                    0: ps = 6'd32;
                    1: ps = 6'd16;
                    2: ps = 6'd8;
                    3: ps = 6'd4;
                    default: ps = 6'($urandom);
                endcase
            step();
            model_check();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
